// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage stall/drain controller.
// Holds the drain FSM state encoding and the NOP instruction word
// that a bubble represents in the ID->EXE register.
package id_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_NOTIFY  = 2'd2,
    ST_RELEASE = 2'd3
  } id_state_t;

  localparam logic [31:0] ID_NOP = 32'h0000_0000;

endpackage

// File: rtl/id_hazard_match.sv
// Operand-vs-destination comparator for one hazard class.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller folds the result into its stall logic.
module id_hazard_match (
  input  logic [4:0] reg_a,
  input  logic [4:0] reg_b,
  input  logic       uses_a,
  input  logic       uses_b,
  input  logic [4:0] write_reg,
  input  logic       qual,
  output logic       match
);

  // Register $0 is hardwired to zero, so writes to it never create a dependency.
  always_comb begin
    match = qual && (write_reg != 5'd0) &&
            ((uses_a && (reg_a == write_reg)) || (uses_b && (reg_b == write_reg)));
  end

endmodule

// File: rtl/id_stall_controller.sv
// ID-stage hazard interlock and syscall/LL/SC drain sequencer.
// Latency: Stall_ID/Bubble_EXE combinational; SYS/Draining registered.
// Backpressure: MEM_Busy freezes the FSM and holds ID without bubbling.
// Optional macro ID_BRANCH_INTERLOCK_EN adds a branch-operand interlock.
module id_stall_controller
  import id_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_Valid,
  input  logic [4:0] ID_RegA,
  input  logic [4:0] ID_RegB,
  input  logic       ID_UsesA,
  input  logic       ID_UsesB,
  input  logic       ID_Branch,
  input  logic       ID_Syscall,
  input  logic       ID_NoNotify,
  input  logic [4:0] EXE_WriteReg,
  input  logic       EXE_RegWrite,
  input  logic       EXE_MemRead,
  input  logic       MEM_Busy,
  output logic       Stall_ID,
  output logic       Bubble_EXE,
  output logic       SYS,
  output logic       Draining
);

  // The syscall-detect cycle already inserts one bubble, so the counter
  // covers the remaining DRAIN_CYCLES-1 bubbles before NOTIFY.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  id_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sys_nxt;
  logic             load_use;
  logic             branch_hz;

  id_hazard_match u_load_use (
    .reg_a     (ID_RegA),
    .reg_b     (ID_RegB),
    .uses_a    (ID_UsesA),
    .uses_b    (ID_UsesB),
    .write_reg (EXE_WriteReg),
    .qual      (ID_Valid & EXE_MemRead & EXE_RegWrite),
    .match     (load_use)
  );

`ifdef ID_BRANCH_INTERLOCK_EN
  // Branches compare in ID, so any in-flight ALU result they read must land first.
  id_hazard_match u_branch (
    .reg_a     (ID_RegA),
    .reg_b     (ID_RegB),
    .uses_a    (ID_UsesA),
    .uses_b    (ID_UsesB),
    .write_reg (EXE_WriteReg),
    .qual      (ID_Valid & ID_Branch & EXE_RegWrite),
    .match     (branch_hz)
  );
`else
  // Branch operands are forwarded elsewhere; ID_Branch is intentionally unused.
  logic unused_branch;
  assign unused_branch = ID_Branch;
  assign branch_hz     = 1'b0;
`endif

  // State register, drain counter and registered status outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_RUN;
      cnt      <= '0;
      SYS      <= 1'b0;
      Draining <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      SYS      <= sys_nxt;
      Draining <= (state_nxt != ST_RUN);
    end
  end

  // Next-state and stall/bubble decode; MEM_Busy overrides everything and freezes state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sys_nxt    = SYS;
    Stall_ID   = 1'b0;
    Bubble_EXE = 1'b0;
    if (MEM_Busy) begin
      Stall_ID = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          sys_nxt = 1'b0;
          if (ID_Valid && ID_Syscall) begin
            Stall_ID   = 1'b1;
            Bubble_EXE = 1'b1;
            cnt_nxt    = CNT_LOAD;
            state_nxt  = (CNT_LOAD == '0) ? ST_NOTIFY : ST_DRAIN;
          end else if (branch_hz || load_use) begin
            Stall_ID   = 1'b1;
            Bubble_EXE = 1'b1;
          end
        end
        ST_DRAIN: begin
          Stall_ID   = 1'b1;
          Bubble_EXE = 1'b1;
          if (cnt <= CNT_ONE) begin
            cnt_nxt   = '0;
            state_nxt = ST_NOTIFY;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        ST_NOTIFY: begin
          Stall_ID   = 1'b1;
          Bubble_EXE = 1'b1;
          sys_nxt    = !ID_NoNotify;
          state_nxt  = ST_RELEASE;
        end
        ST_RELEASE: begin
          sys_nxt   = 1'b0;
          state_nxt = ST_RUN;
        end
        default: begin
          sys_nxt   = 1'b0;
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_stall_controller.sv
// Self-checking bench for id_stall_controller (default DRAIN_CYCLES=3).
// Expected {Stall_ID,Bubble_EXE,SYS,Draining} is queued when inputs are driven
// and compared on the following falling edge.
module tb_id_stall_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ID_Valid, ID_UsesA, ID_UsesB, ID_Branch, ID_Syscall, ID_NoNotify;
  logic [4:0] ID_RegA, ID_RegB, EXE_WriteReg;
  logic       EXE_RegWrite, EXE_MemRead, MEM_Busy;
  logic       Stall_ID, Bubble_EXE, SYS, Draining;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  id_stall_controller #(.DRAIN_CYCLES(3), .CNT_W(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ID_Valid     (ID_Valid),
    .ID_RegA      (ID_RegA),
    .ID_RegB      (ID_RegB),
    .ID_UsesA     (ID_UsesA),
    .ID_UsesB     (ID_UsesB),
    .ID_Branch    (ID_Branch),
    .ID_Syscall   (ID_Syscall),
    .ID_NoNotify  (ID_NoNotify),
    .EXE_WriteReg (EXE_WriteReg),
    .EXE_RegWrite (EXE_RegWrite),
    .EXE_MemRead  (EXE_MemRead),
    .MEM_Busy     (MEM_Busy),
    .Stall_ID     (Stall_ID),
    .Bubble_EXE   (Bubble_EXE),
    .SYS          (SYS),
    .Draining     (Draining)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got stall/bubble/sys/drain=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_Valid = 0; ID_UsesA = 0; ID_UsesB = 0; ID_Branch = 0;
    ID_Syscall = 0; ID_NoNotify = 0; ID_RegA = 0; ID_RegB = 0;
    EXE_WriteReg = 0; EXE_RegWrite = 0; EXE_MemRead = 0; MEM_Busy = 0;
  endtask

  // Inputs are already driven for this cycle; queue the expectation, check at negedge,
  // then advance to 1 time unit past the next rising edge.
  task automatic step(input string tag, input logic [3:0] exp);
    logic [3:0] e;
    exp_q.push_back(exp);
    @(negedge CLK);
    e = exp_q.pop_front();
    chk(tag, {Stall_ID, Bubble_EXE, SYS, Draining}, e);
    @(posedge CLK);
    #1;
  endtask

  task automatic syscall_in(input logic nn);
    ID_Valid = 1; ID_Syscall = 1; ID_NoNotify = nn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    RESET = 1'b0;
    #2;
    step("reset_idle", 4'b0000);
    RESET = 1'b1;
    step("run_idle", 4'b0000);

    // Load-use on rs
    ID_Valid = 1; ID_UsesA = 1; ID_RegA = 5'd8;
    EXE_MemRead = 1; EXE_RegWrite = 1; EXE_WriteReg = 5'd8;
    step("lu_rs", 4'b1100);
    EXE_MemRead = 0; EXE_RegWrite = 0; EXE_WriteReg = 0;
    step("lu_clear", 4'b0000);
    // Destination $0 never stalls
    EXE_MemRead = 1; EXE_RegWrite = 1; EXE_WriteReg = 0; ID_RegA = 0;
    step("lu_r0", 4'b0000);
    // Load-use on rt
    idle(); ID_Valid = 1; ID_UsesB = 1; ID_RegB = 5'd9;
    EXE_MemRead = 1; EXE_RegWrite = 1; EXE_WriteReg = 5'd9;
    step("lu_rt", 4'b1100);
    ID_UsesB = 0;
    step("lu_rt_unused", 4'b0000);
    ID_UsesB = 1; ID_Valid = 0;
    step("lu_invalid", 4'b0000);
    ID_Valid = 1; MEM_Busy = 1;
    step("lu_busy", 4'b1000);
    // Non-load producer does not stall ALU consumer
    idle(); ID_Valid = 1; ID_UsesA = 1; ID_RegA = 5'd4;
    EXE_RegWrite = 1; EXE_WriteReg = 5'd4;
    step("alu_fwd", 4'b0000);
    // Branch reading an ALU result in EXE
    ID_Branch = 1;
`ifdef ID_BRANCH_INTERLOCK_EN
    step("br_interlock", 4'b1100);
`else
    step("br_interlock", 4'b0000);
`endif
    idle();
    step("br_after", 4'b0000);

    // Invalid syscall ignored
    ID_Syscall = 1;
    step("sc_invalid", 4'b0000);

    // Syscall with notify
    idle(); syscall_in(0);
    step("sc_detect", 4'b1100);
    step("sc_drain1", 4'b1101);
    step("sc_drain2", 4'b1101);
    step("sc_notify", 4'b1101);
    step("sc_release", 4'b0011);
    idle();
    step("sc_done", 4'b0000);

    // LL/SC: same timing, no SYS
    syscall_in(1);
    step("ll_detect", 4'b1100);
    step("ll_drain1", 4'b1101);
    step("ll_drain2", 4'b1101);
    step("ll_notify", 4'b1101);
    step("ll_release", 4'b0001);
    idle();
    step("ll_done", 4'b0000);

    // MEM_Busy for two cycles inside DRAIN
    syscall_in(0);
    step("mb_detect", 4'b1100);
    MEM_Busy = 1;
    step("mb_busy1", 4'b1001);
    step("mb_busy2", 4'b1001);
    MEM_Busy = 0;
    step("mb_drain1", 4'b1101);
    step("mb_drain2", 4'b1101);
    step("mb_notify", 4'b1101);
    step("mb_release", 4'b0011);
    idle();
    step("mb_done", 4'b0000);

    // Back-to-back syscalls: SYS pulses 5 cycles apart
    syscall_in(0);
    step("bb_detect_a", 4'b1100);
    step("bb_drain_a1", 4'b1101);
    step("bb_drain_a2", 4'b1101);
    step("bb_notify_a", 4'b1101);
    step("bb_release_a", 4'b0011);
    step("bb_detect_b", 4'b1100);
    step("bb_drain_b1", 4'b1101);
    step("bb_drain_b2", 4'b1101);
    step("bb_notify_b", 4'b1101);
    step("bb_release_b", 4'b0011);
    idle();
    step("bb_done", 4'b0000);

    // Reset mid-drain (counter at 1) aborts silently
    syscall_in(0);
    step("rst_detect", 4'b1100);
    step("rst_drain1", 4'b1101);
    idle(); RESET = 1'b0;
    step("rst_abort", 4'b0000);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_no_sys", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
